bitnet_dot_seq: RTL and testbench
=================================

Name: bitnet_dot_seq

Overview:
Sequencing stage directly upstream of, and wrapping, the BitNet FMA datapath. It accepts packed beats of LANES int8 activations plus LANES FP4 (E3M0) weights over a valid/ready stream. It feeds them one lane per cycle through the saturating shift-add FMA, chaining the 16-bit accumulator into the FMA's c input. After the beat flagged last, it emits the clamped dot-product result on a valid/ready output stream.

Parameters:
LANES, 8, activation/weight pairs per input beat (power of 2, 2..16)
LANE_W, $clog2(LANES), width of the lane index counter (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_act  in  LANES*8  signed int8 activations; lane i = [8i+7:8i]
in_wgt  in  LANES*4  FP4 E3M0 weights; lane i = [4i+3:4i]
in_last  in  1  beat is final beat of current vector
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  16  signed saturated dot-product

Behaviour:
- Reset, asynchronous: state=IDLE, acc=0, lane=0, in_ready=1, out_valid=0, out_data=0; latched beat regs=0.
- FMA per lane: b==4'b0000 -> acc unchanged.
- FMA per lane, otherwise: s = sext16(a) << b[2:0], truncated to 16 bits; r17 = b[3] ? acc - s : acc + s.
- FMA per lane, clamp: acc = clamp(r17, -32768, 32767), applied every lane. Clamping is sequential, not on the final sum.
- Encoding 4'b1000 means -1x.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_act/in_wgt/in_last, lane<=0, go to RUN. acc is kept, so a vector spans beats.
- RUN: in_ready=0. Each cycle acc <= fma(act[lane], wgt[lane], acc) and lane<=lane+1. Lanes are processed in order 0..LANES-1.
- RUN exit, at lane==LANES-1: go to DONE if latched last=1, else to IDLE.
- DONE: out_valid=1, out_data=acc (registered, stable while stalled), in_ready=0.
- DONE, on out_ready: out_valid<=0, acc<=0, go to IDLE.
- Latency: last beat accepted at edge t -> out_valid high after edge t+LANES.
- Throughput: one beat per LANES+1 cycles, plus result handshake cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; the producer must hold the beat stable until accepted.
- Reset mid-RUN/DONE discards the partial vector and any pending result; the next vector starts from acc=0.
- Once acc is clamped, later lanes continue from the clamped value (e.g. 32767 then -1x5 -> 32762).

Optional Feature:
BITNET_SAT_FLAG_EN. When defined, adds output out_sat (1 bit, reset 0).
- A sticky flag is set whenever any lane's r17 is outside the 16-bit range during the current vector.
- out_sat is valid with out_data and is cleared together with acc on the out_ready handshake.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package bitnet_pkg holds: ACC_MIN/ACC_MAX (-32768/32767), FP4 field positions (sign bit 3, exp [2:0]), FP4_ZERO=4'b0000, and the state enum {IDLE, RUN, DONE}.
- Natural sub-module: bitnet_fma, the combinational saturating shift-add, instantiated once. The sequencer muxes the lane's a/b into it and feeds acc as c.

Test Plan:
- All lanes act=1, wgt=4'b0001 (+2x), in_last=1 -> out_data=16 after 8 cycles; out_sat=0.
- Two beats, act=100, wgt=4'b0111 (+128x) -> acc clamps to 32767 at lane 2, final out_data=32767, out_sat=1.
- act=8'h80 (-128), wgt=4'b0111 -> lane0 -16384, lane1 -32768, remaining lanes hold clamp; out_data=-32768.
- All wgt=0 -> out_data=0. Lane0 act=5, wgt=4'b1000, others wgt=0 -> out_data=-5. Lane0 act=5, wgt=4'b1011 (-8x) -> out_data=-40.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data stable, in_ready=0; on out_ready=1, next beat is accepted the following cycle, starting from acc=0.
- Assert reset 3 cycles into RUN -> all outputs 0 immediately (asynchronous). Resend a single beat of act=1, wgt=4'b0000 except lane0 wgt=4'b0000 -> out_data=0, with no residue from the aborted vector.

Source files
------------

// File: rtl/bitnet_pkg.sv
// Shared constants and types for the BitNet dot-product sequencer and its FMA.
// Used by bitnet_fma and bitnet_dot_seq.
package bitnet_pkg;

    localparam logic signed [15:0] ACC_MIN = 16'sh8000;
    localparam logic signed [15:0] ACC_MAX = 16'sh7FFF;

    // FP4 E3M0 weight: sign in bit 3, power-of-two exponent in [2:0]
    localparam int         FP4_SIGN_BIT = 3;
    localparam int         FP4_EXP_MSB  = 2;
    localparam int         FP4_EXP_LSB  = 0;
    localparam logic [3:0] FP4_ZERO     = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bitnet_fma.sv
// Combinational saturating shift-add: acc = clamp(c +/- (a << exp)), weight 0 leaves c untouched.
// ovf_o flags that the unclamped 17-bit result left the 16-bit range.
module bitnet_fma
    import bitnet_pkg::*;
(
    input  logic signed [7:0]  a_i,
    input  logic        [3:0]  b_i,
    input  logic signed [15:0] c_i,
    output logic signed [15:0] acc_o,
    output logic               ovf_o
);

    logic signed [15:0] a_ext;
    logic signed [15:0] shifted;
    logic signed [16:0] c_ext;
    logic signed [16:0] s_ext;
    logic signed [16:0] r17;

    always_comb begin
        a_ext   = {{8{a_i[7]}}, a_i};
        shifted = a_ext <<< b_i[FP4_EXP_MSB:FP4_EXP_LSB];
        c_ext   = {c_i[15], c_i};
        s_ext   = {shifted[15], shifted};

        if (b_i == FP4_ZERO) begin
            r17 = c_ext;
        end else if (b_i[FP4_SIGN_BIT]) begin
            r17 = c_ext - s_ext;
        end else begin
            r17 = c_ext + s_ext;
        end

        // Bits 16 and 15 disagree exactly when r17 is outside int16
        ovf_o = r17[16] ^ r17[15];
        if (ovf_o) begin
            acc_o = r17[16] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_o = r17[15:0];
        end
    end

endmodule

// File: rtl/bitnet_dot_seq.sv
// Beat-to-lane sequencer around bitnet_fma: one lane per cycle, result after the last beat.
// Optional sticky saturation output out_sat_o when BITNET_SAT_FLAG_EN is defined.
//
// state | meaning
// IDLE  | ready for a beat; acc carries the partial vector across beats
// RUN   | stepping lanes 0..LANES-1 of the latched beat through the FMA
// DONE  | result presented on out_data_o until out_ready_i
module bitnet_dot_seq
    import bitnet_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES*8-1:0]     in_act_i,
    input  logic [LANES*4-1:0]     in_wgt_i,
    input  logic                   in_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic signed [15:0]     out_data_o
`ifdef BITNET_SAT_FLAG_EN
    ,
    output logic                   out_sat_o
`endif
);

    localparam int LANE_W = $clog2(LANES);

    state_e                state_q, state_d;
    logic signed [15:0]    acc_q, acc_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [LANES*8-1:0]    act_q, act_d;
    logic [LANES*4-1:0]    wgt_q, wgt_d;
    logic                  last_q, last_d;

    logic signed [7:0]     lane_act;
    logic [3:0]            lane_wgt;
    logic signed [15:0]    fma_acc;
    logic                  fma_ovf;

    assign lane_act = act_q[{lane_q, 3'b000} +: 8];
    assign lane_wgt = wgt_q[{lane_q, 2'b00} +: 4];

    bitnet_fma u_fma (
        .a_i   (lane_act),
        .b_i   (lane_wgt),
        .c_i   (acc_q),
        .acc_o (fma_acc),
        .ovf_o (fma_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        lane_d  = lane_q;
        act_d   = act_q;
        wgt_d   = wgt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    act_d   = in_act_i;
                    wgt_d   = in_wgt_i;
                    last_d  = in_last_i;
                    lane_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = fma_acc;
                lane_d = lane_q + LANE_W'(1);
                if (lane_q == LANE_W'(LANES - 1)) begin
                    state_d = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            lane_q  <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lane_q  <= lane_d;
            act_q   <= act_d;
            wgt_q   <= wgt_d;
            last_q  <= last_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign out_data_o  = acc_q;

`ifdef BITNET_SAT_FLAG_EN
    logic sat_q, sat_d;

    // Sticky across all beats of a vector; cleared with acc on the result handshake
    always_comb begin
        sat_d = sat_q;
        if (state_q == RUN) begin
            sat_d = sat_q | fma_ovf;
        end else if (state_q == DONE && out_ready_i) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign out_sat_o = sat_q;
`else
    logic unused_ovf;
    assign unused_ovf = fma_ovf;
`endif

endmodule

// File: tb/tb_bitnet_dot_seq.sv
// Self-checking bench for bitnet_dot_seq: integer reference model, per-cycle result compare,
// directed literal cases, reset abort and randomized multi-beat vectors.
module tb_bitnet_dot_seq;

    localparam int LANES = 8;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [LANES*8-1:0]   in_act_i;
    logic [LANES*4-1:0]   in_wgt_i;
    logic                 in_last_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic signed [15:0]   out_data_o;
`ifdef BITNET_SAT_FLAG_EN
    logic                 out_sat_o;
`endif

    bitnet_dot_seq #(.LANES(LANES)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_act_i    (in_act_i),
        .in_wgt_i    (in_wgt_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o)
`ifdef BITNET_SAT_FLAG_EN
        ,
        .out_sat_o   (out_sat_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    int m_acc = 0;
    int m_sat = 0;
    int exp_data[$];
    int exp_sat[$];

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference: integer dot product with a clamp after every non-zero weight
    task automatic model_beat(input logic [LANES*8-1:0] av, input logic [LANES*4-1:0] wv,
                              input bit last);
        for (int i = 0; i < LANES; i++) begin
            int a;
            int s;
            int r;
            logic [3:0] w;
            a = int'($signed(av[i*8 +: 8]));
            w = wv[i*4 +: 4];
            if (w == 4'b0000) continue;
            s = a * (1 << w[2:0]);
            r = w[3] ? (m_acc - s) : (m_acc + s);
            if (r > 32767) begin
                m_acc = 32767;
                m_sat = 1;
            end else if (r < -32768) begin
                m_acc = -32768;
                m_sat = 1;
            end else begin
                m_acc = r;
            end
        end
        if (last) begin
            exp_data.push_back(m_acc);
            exp_sat.push_back(m_sat);
            m_acc = 0;
            m_sat = 0;
        end
    endtask

    // Compare process: every cycle a result is presented it must match the model
    always @(negedge clk_i) begin
        if (!reset_i && out_valid_o) begin
            if (exp_data.size() == 0) begin
                check_int("spurious_valid", 1, 0);
            end else begin
                check_int("out_data", int'(out_data_o), exp_data[0]);
`ifdef BITNET_SAT_FLAG_EN
                check_int("out_sat", int'(out_sat_o), exp_sat[0]);
`endif
                check_int("in_ready_in_done", int'(in_ready_o), 0);
                if (out_ready_i) begin
                    void'(exp_data.pop_front());
                    void'(exp_sat.pop_front());
                end
            end
        end
    end

    function automatic logic [LANES*8-1:0] fill_act(input int a);
        logic [LANES*8-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*8 +: 8] = 8'(a);
        return v;
    endfunction

    function automatic logic [LANES*4-1:0] fill_wgt(input logic [3:0] w);
        logic [LANES*4-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*4 +: 4] = w;
        return v;
    endfunction

    function automatic logic [LANES*4-1:0] lane0_wgt(input logic [3:0] w);
        logic [LANES*4-1:0] v;
        v = '0;
        v[3:0] = w;
        return v;
    endfunction

    task automatic send_beat(input logic [LANES*8-1:0] av, input logic [LANES*4-1:0] wv,
                             input bit last);
        int n;
        n = 0;
        in_act_i   = av;
        in_wgt_i   = wv;
        in_last_i  = last;
        in_valid_i = 1'b1;
        while (!in_ready_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!in_ready_o) begin
            check_int("accept_timeout", n, 0);
            in_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        model_beat(av, wv, last);
    endtask

    task automatic wait_result(input bit use_lit, input int lit, input int lit_sat,
                               input int stall);
        int n;
        n = 0;
        out_ready_i = 1'b0;
        while (!out_valid_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_int("latency", n, LANES);
        if (!out_valid_o) return;
        if (use_lit) begin
            check_int("lit_data", int'(out_data_o), lit);
            if (exp_data.size() > 0) check_int("model_pin", exp_data[0], lit);
`ifdef BITNET_SAT_FLAG_EN
            check_int("lit_sat", int'(out_sat_o), lit_sat);
`else
            if (lit_sat < 0) check_int("lit_sat_arg", lit_sat, 0);
`endif
        end
        repeat (stall) begin
            @(posedge clk_i); #1;
        end
        check_int("stall_valid", int'(out_valid_o), 1);
        if (use_lit) check_int("stall_data", int'(out_data_o), lit);
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check_int("post_valid", int'(out_valid_o), 0);
        check_int("post_ready", int'(in_ready_o), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i     = 1'b1;
        in_valid_i  = 1'b0;
        in_act_i    = '0;
        in_wgt_i    = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b0;
        #1;
        check_int("rst_out_valid", int'(out_valid_o), 0);
        check_int("rst_in_ready", int'(in_ready_o), 1);
        check_int("rst_out_data", int'(out_data_o), 0);
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 1'b0;

        // +2x on all lanes of ones -> 16
        send_beat(fill_act(1), fill_wgt(4'b0001), 1'b1);
        wait_result(1'b1, 16, 0, 0);

        // 100 * 128 over two beats saturates at lane 2
        send_beat(fill_act(100), fill_wgt(4'b0111), 1'b0);
        send_beat(fill_act(100), fill_wgt(4'b0111), 1'b1);
        wait_result(1'b1, 32767, 1, 0);

        // -128 * 128 reaches the negative rail
        send_beat(fill_act(-128), fill_wgt(4'b0111), 1'b1);
        wait_result(1'b1, -32768, 1, 1);

        send_beat(fill_act(77), fill_wgt(4'b0000), 1'b1);
        wait_result(1'b1, 0, 0, 0);

        send_beat(fill_act(5), lane0_wgt(4'b1000), 1'b1);
        wait_result(1'b1, -5, 0, 0);

        send_beat(fill_act(5), lane0_wgt(4'b1011), 1'b1);
        wait_result(1'b1, -40, 0, 0);

        // Clamped value carries into later lanes: 32767 then -1x5
        send_beat(fill_act(100), fill_wgt(4'b0111), 1'b0);
        send_beat(fill_act(5), lane0_wgt(4'b1000), 1'b1);
        wait_result(1'b1, 32762, 1, 5);

        // Reset three cycles into RUN of the last beat of a partially accumulated vector
        send_beat(fill_act(1), fill_wgt(4'b0001), 1'b0);
        send_beat(fill_act(1), fill_wgt(4'b0001), 1'b1);
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        #1;
        check_int("abort_out_valid", int'(out_valid_o), 0);
        check_int("abort_in_ready", int'(in_ready_o), 1);
        check_int("abort_out_data", int'(out_data_o), 0);
        m_acc = 0;
        m_sat = 0;
        exp_data.delete();
        exp_sat.delete();
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        send_beat(fill_act(1), fill_wgt(4'b0000), 1'b1);
        wait_result(1'b1, 0, 0, 0);
        send_beat(fill_act(1), lane0_wgt(4'b0001), 1'b1);
        wait_result(1'b1, 2, 0, 0);

        // Randomized vectors of 1..3 beats, stray out_ready outside DONE
        for (int v = 0; v < 40; v++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
                logic [LANES*8-1:0] av;
                logic [LANES*4-1:0] wv;
                for (int i = 0; i < LANES; i++) begin
                    av[i*8 +: 8] = 8'($urandom);
                    wv[i*4 +: 4] = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
                end
                out_ready_i = 1'($urandom_range(0, 1));
                send_beat(av, wv, b == nb - 1);
            end
            wait_result(1'b0, 0, 0, int'($urandom_range(0, 4)));
        end

        check_int("queue_drained", exp_data.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
